// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling at N clocks per bit, byte + one-cycle valid/error strobes.
// Latency pin start edge -> data_valid is 2 + floor(N/2) + 9N + 1 cycles; no backpressure, read_buffer held until next byte.
module uart_rx #(
   parameter int unsigned CLKS_MIN = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_line,
   input  logic [15:0] baud_rate_control,
   output logic [7:0]  read_buffer,
   output logic        data_valid,
   output logic        frame_error,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] CLKS_MIN_W = 16'(CLKS_MIN);

   state_t      state_q, state_d;
   logic        sync1_q, rx_s_q, rx_prev_q;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] n_q, n_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rbuf_q, rbuf_d;
   logic        dv_q, dv_d;
   logic        fe_q, fe_d;
   logic [15:0] n_eff;
   logic        expire;

   assign n_eff  = (baud_rate_control < CLKS_MIN_W) ? CLKS_MIN_W : baud_rate_control;
   assign expire = (cnt_q == 16'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      rbuf_d  = rbuf_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // Only a true 1->0 transition starts a frame; a line held low stays ignored.
            if (rx_prev_q && !rx_s_q) begin
               n_d     = n_eff;
               cnt_d   = (n_eff >> 1) - 16'd1;
               state_d = START;
            end
         end
         START: begin
            if (!expire) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!rx_s_q) begin
               cnt_d   = n_q - 16'd1;
               idx_d   = 3'd0;
               state_d = DATA;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (!expire) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shift_d[idx_q] = rx_s_q;
               cnt_d          = n_q - 16'd1;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // Return to IDLE at mid-stop so a following start edge is not missed.
            if (!expire) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               if (rx_s_q) begin
                  rbuf_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         n_q       <= 16'd0;
         idx_q     <= 3'd0;
         shift_q   <= 8'd0;
         rbuf_q    <= 8'd0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         sync1_q   <= data_line;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rbuf_q    <= rbuf_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
      end
   end

   assign read_buffer = rbuf_q;
   assign data_valid  = dv_q;
   assign frame_error = fe_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the line driven by the UART transmitter (`data_line`). It recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) using the same `baud_rate_control` clocks-per-bit convention as the transmitter. Each received byte is presented on a parallel output with a one-cycle valid strobe. The block sits directly downstream of the TX stage: loopback, or the far end of the link.

## Interface
- `CLKS_MIN`, default 2: smallest legal clocks-per-bit. Smaller `baud_rate_control` values are treated as `CLKS_MIN`.
- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: asynchronous, active-low reset.
- `data_line` input 1: serial line. Asynchronous to `clk`; idle high.
- `baud_rate_control` input 16: clocks per bit, N.
- `read_buffer` output 8: last correctly framed byte.
- `data_valid` output 1: one-cycle pulse when a new byte is in `read_buffer`.
- `frame_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high while a frame is being received.

## Operation
- Input sync:
  - `data_line` passes through a 2-flop synchronizer; both flops reset to 1.
  - All logic below uses the synchronized value `rx_s`.
- Reset values: `read_buffer`=0x00, `data_valid`=0, `frame_error`=0, `busy`=0, state=IDLE, counters=0.
- Reset has priority. Asserting it mid-frame aborts the frame with no pulse, and `read_buffer` clears.
- `baud_rate_control` is latched into N at start detection. Changes mid-frame are ignored. If the value is below `CLKS_MIN`, N=`CLKS_MIN`.
- 16-bit period counter counts cycles within a bit; 3-bit bit index; 8-bit shift register.
- States:
  - IDLE:
    - `busy`=0.
    - Falling edge of `rx_s` (previous 1, current 0) → START; counter loads floor(N/2)-1.
    - A low `rx_s` without a falling edge (line held low) is ignored.
  - START:
    - When the counter reaches 0, sample `rx_s`.
    - If 0 → DATA, counter loads N-1, bit index=0.
    - If 1 → false start; return to IDLE with no pulse.
  - DATA:
    - At each counter expiry, shift `rx_s` into bit [index] (LSB first) and reload N-1.
    - After index 7 → STOP.
  - STOP:
    - At counter expiry, sample `rx_s`.
    - If 1: `read_buffer` ← shift register and `data_valid` pulses.
    - If 0: `frame_error` pulses and `read_buffer` is unchanged.
    - Either way → IDLE.
- Break or held-low line after a framing error: IDLE needs a fresh falling edge, so no spurious frames are received.
- `data_valid` and `frame_error` are never high in the same cycle.
- No overrun handling. The consumer must take `read_buffer` before the next `data_valid`; it is held stable until then.

## Timing
- T0 = the first cycle `rx_s` is seen low, 2 cycles after the pin falls.
- Sample instants:
  - Start-bit check at T0+floor(N/2).
  - Data bit i (i=0..7) at T0+floor(N/2)+(i+1)·N.
  - Stop bit at T0+floor(N/2)+9·N.
- `data_valid`/`frame_error` are registered and high during the cycle after the stop sample, for exactly 1 cycle. `read_buffer` is updated in that same cycle.
- `busy` rises at T0+1 and falls in the same cycle `data_valid`/`frame_error` rises. It also falls the cycle after a false-start check.
- Back-to-back frames:
  - IDLE is re-entered half a bit before the stop bit ends.
  - A start edge immediately following the stop bit is detected with no lost cycles.
- Total latency from pin start edge to `data_valid`: 2 + floor(N/2) + 9·N + 1 cycles.
- Tolerates transmitter clock mismatch up to ±(N/2-1)/(10·N) of the bit period.

## Test plan
- N=16, transmit 0xA5 with a model TX → `data_valid` is a single pulse at 2+8+144+1=155 cycles after the start edge; `read_buffer`=0xA5; `frame_error` never asserts.
- N=16, low glitch of 3 cycles on an idle line → `busy` pulses, no `data_valid`/`frame_error`, state returns to IDLE, next real frame 0x3C is received correctly.
- N=16, frame 0x5A with stop bit forced 0, then line held low for 40 bits, then frame 0x11 → one `frame_error` pulse, `read_buffer` stays at its prior value, no frames during the low period, then 0x11 is received.
- N=10, frames 0x00, 0xFF, 0x81 sent back-to-back with no idle gap → three `data_valid` pulses exactly 100 cycles apart with the correct bytes.
- N=16, assert `reset` low mid-data-bit 4 of frame 0xC3, release, send 0x7E → all outputs read reset values while reset is low, no pulse for 0xC3, 0x7E is received.
- `baud_rate_control`=0 and =2, frame 0x96 sent at 2 clocks/bit → received as 0x96 in both cases.
